// File: rtl/fibo_run_controller.sv
// Run sequencer for the Fibonacci core: debounces the start button, range-checks N,
// launches the core, waits for done with a timeout and holds the result for display.
module fibo_run_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int N_MAX           = 47
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic [7:0]  n_in,
    output logic        cpu_start,
    output logic [7:0]  cpu_n,
    input  logic        cpu_done,
    input  logic [31:0] cpu_result,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        err_range,
    output logic        err_timeout,
    output logic        disp_sel
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    N_MAX_V  = 8'(N_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_DONE, S_ERROR
    } state_t;

    logic          btn_q;
    logic [DW-1:0] deb_cnt_q;
    logic          btn_flip;
    logic          press_evt;

    // The Nth consecutive differing sample flips btn_q; a rising flip is the press event.
    assign btn_flip  = (start_btn != btn_q) && (deb_cnt_q == DEB_LAST);
    assign press_evt = btn_flip && start_btn;

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else if (start_btn == btn_q) begin
            deb_cnt_q <= '0;
        end else if (btn_flip) begin
            btn_q     <= start_btn;
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
        end
    end

    state_t        state_q, state_d;
    logic [7:0]    n_lat_q;
    logic [TW-1:0] timer_q;
    logic          cpu_start_q;
    logic [7:0]    cpu_n_q;
    logic          busy_q;
    logic [31:0]   result_q;
    logic          result_valid_q;
    logic          err_range_q;
    logic          err_timeout_q;
    logic          disp_sel_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (press_evt) state_d = S_CHECK;
            S_CHECK:  state_d = (n_lat_q > N_MAX_V) ? S_ERROR : S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (cpu_done)                state_d = S_DONE;
                else if (timer_q == TMO_LAST) state_d = S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            n_lat_q        <= '0;
            timer_q        <= '0;
            cpu_start_q    <= 1'b0;
            cpu_n_q        <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_range_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
            disp_sel_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_start_q <= (state_d == S_LAUNCH);
            busy_q      <= (state_d == S_CHECK) || (state_d == S_LAUNCH) || (state_d == S_WAIT);
            disp_sel_q  <= (state_d == S_DONE);
            if (state_d == S_LAUNCH) cpu_n_q <= n_lat_q;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: if (press_evt) n_lat_q <= n_in;
                S_CHECK: begin
                    result_valid_q <= 1'b0;
                    err_timeout_q  <= 1'b0;
                    err_range_q    <= (n_lat_q > N_MAX_V);
                end
                S_LAUNCH: timer_q <= '0;
                S_WAIT: begin
                    if (cpu_done) begin
                        result_q       <= cpu_result;
                        result_valid_q <= 1'b1;
                    end else if (timer_q == TMO_LAST) begin
                        err_timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_start    = cpu_start_q;
    assign cpu_n        = cpu_n_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err_range    = err_range_q;
    assign err_timeout  = err_timeout_q;
    assign disp_sel     = disp_sel_q;

endmodule

// File: tb/tb_fibo_run_controller.sv
// Directed bench for fibo_run_controller: debounce, launch latency, range and timeout
// errors, done/timeout priority and reset abort, with hand-computed expectations.
module tb_fibo_run_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_btn = 1'b0;
    logic [7:0]  n_in = 8'd0;
    logic        cpu_start;
    logic [7:0]  cpu_n;
    logic        cpu_done = 1'b0;
    logic [31:0] cpu_result = 32'd0;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic        err_range;
    logic        err_timeout;
    logic        disp_sel;

    int checks = 0;
    int errors = 0;
    int starts;

    always #5 clk = ~clk;

    fibo_run_controller dut (
        .clk          (clk),
        .reset        (reset),
        .start_btn    (start_btn),
        .n_in         (n_in),
        .cpu_start    (cpu_start),
        .cpu_n        (cpu_n),
        .cpu_done     (cpu_done),
        .cpu_result   (cpu_result),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .err_range    (err_range),
        .err_timeout  (err_timeout),
        .disp_sel     (disp_sel)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge, inputs change at the same point.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Idle 4 cycles so any previous release has settled, then hold high for 4 samples.
    task automatic press();
        step(4);
        start_btn = 1'b1;
        step(4);
        start_btn = 1'b0;
    endtask

    task automatic count_starts(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (cpu_start) cnt++;
        end
    endtask

    task automatic serve(input int delay, input logic [31:0] val);
        step(delay);
        cpu_done   = 1'b1;
        cpu_result = val;
        step(1);
        cpu_done   = 1'b0;
        cpu_result = 32'd0;
    endtask

    function automatic logic [63:0] outs();
        return 64'({cpu_start, cpu_n, busy, result, result_valid, err_range, err_timeout, disp_sel});
    endfunction

    initial begin
        // 1) reset for 3 cycles, then idle with no launch
        step(3);
        check("reset_outs", outs(), 64'd0);
        reset = 1'b1;
        count_starts(20, starts);
        check("idle_no_start", 64'(starts), 64'd0);
        check("idle_outs", outs(), 64'd0);

        // 2) short press (3 samples) is rejected, a 4-sample press launches 2 cycles later
        n_in = 8'd10;
        start_btn = 1'b1;
        step(3);
        start_btn = 1'b0;
        count_starts(10, starts);
        check("short_press_start", 64'(starts), 64'd0);
        check("short_press_busy", 64'(busy), 64'd0);
        start_btn = 1'b1;
        step(4);
        start_btn = 1'b0;
        check("check_busy", 64'(busy), 64'd1);
        check("check_no_start", 64'(cpu_start), 64'd0);
        n_in = 8'd99;
        step(1);
        check("launch_start", 64'(cpu_start), 64'd1);
        check("launch_cpu_n", 64'(cpu_n), 64'd10);
        step(1);
        check("start_one_cycle", 64'(cpu_start), 64'd0);

        // 3) core answers 55 twelve cycles after the launch
        serve(11, 32'd55);
        check("n10_result", 64'(result), 64'd55);
        check("n10_valid", 64'(result_valid), 64'd1);
        check("n10_disp", 64'(disp_sel), 64'd1);
        check("n10_busy", 64'(busy), 64'd0);
        check("n10_cpu_n_held", 64'(cpu_n), 64'd10);
        $display("run n=10 result=%0d valid=%0d", result, result_valid);

        // 4) N=48 is a range error; N=47 is accepted
        n_in = 8'd48;
        press();
        step(1);
        check("n48_err_range", 64'(err_range), 64'd1);
        check("n48_valid", 64'(result_valid), 64'd0);
        check("n48_result_held", 64'(result), 64'd55);
        check("n48_disp", 64'(disp_sel), 64'd0);
        count_starts(8, starts);
        check("n48_no_start", 64'(starts), 64'd0);
        $display("run n=48 err_range=%0d", err_range);
        n_in = 8'd47;
        press();
        step(1);
        check("n47_start", 64'(cpu_start), 64'd1);
        check("n47_cpu_n", 64'(cpu_n), 64'd47);
        check("n47_err_cleared", 64'(err_range), 64'd0);
        serve(5, 32'd2971215073);
        check("n47_result", 64'(result), 64'd2971215073);
        check("n47_valid", 64'(result_valid), 64'd1);
        $display("run n=47 result=%0d", result);

        // N=0 is forwarded to the core unchanged
        n_in = 8'd0;
        press();
        step(1);
        check("n0_start", 64'(cpu_start), 64'd1);
        check("n0_cpu_n", 64'(cpu_n), 64'd0);
        serve(1, 32'd0);
        check("n0_valid", 64'(result_valid), 64'd1);
        check("n0_result", 64'(result), 64'd0);
        $display("run n=0 result=%0d", result);

        // 5) no done: flag rises after the 1024th WAIT cycle
        n_in = 8'd20;
        press();
        step(1);
        check("tmo_start", 64'(cpu_start), 64'd1);
        step(1024);
        check("tmo_not_yet", 64'(err_timeout), 64'd0);
        check("tmo_still_busy", 64'(busy), 64'd1);
        step(1);
        check("tmo_err", 64'(err_timeout), 64'd1);
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_valid", 64'(result_valid), 64'd0);
        $display("run n=20 err_timeout=%0d", err_timeout);
        // done arriving on the last WAIT cycle wins over the timeout
        press();
        step(1);
        check("late_done_start", 64'(cpu_start), 64'd1);
        serve(1024, 32'd6765);
        check("late_done_err", 64'(err_timeout), 64'd0);
        check("late_done_result", 64'(result), 64'd6765);
        check("late_done_disp", 64'(disp_sel), 64'd1);
        $display("run n=20 result=%0d", result);

        // 6) press during WAIT is dropped; reset mid-WAIT aborts; late done ignored
        n_in = 8'd5;
        press();
        step(1);
        check("abort_start", 64'(cpu_start), 64'd1);
        step(2);
        press();
        step(5);
        check("wait_press_busy", 64'(busy), 64'd1);
        check("wait_press_disp", 64'(disp_sel), 64'd0);
        reset = 1'b0;
        step(1);
        check("abort_outs", outs(), 64'd0);
        step(2);
        reset = 1'b1;
        cpu_done = 1'b1;
        cpu_result = 32'd5;
        step(2);
        check("late_done_ignored", outs(), 64'd0);
        cpu_done = 1'b0;
        cpu_result = 32'd0;
        count_starts(20, starts);
        check("abort_no_start", 64'(starts), 64'd0);
        $display("run n=5 aborted by reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
